// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select line of an N:1 W-bit mux; registered one-hot grant/sel/busy.
// Define RR_MUX_ARBITER_HOLD_LIMIT_EN to preempt an owner after MAX_HOLD cycles when others are waiting.
module rr_mux_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] data_in_i,
  output logic [N-1:0]   grant_o,
  output logic [$clog2(N)-1:0] sel_o,
  output logic           busy_o,
  output logic [W-1:0]   data_out_o
);

  localparam int SW = $clog2(N);

  if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_mux_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, OWNED} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          busy_q, busy_d;
  logic [SW-1:0] ptr_q, ptr_d;

`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`endif

  logic          start;
  logic [SW-1:0] origin;
  logic [SW-1:0] winner;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] i);
    return (i == SW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  // First set request at or after origin, wrapping N-1 -> 0.
  function automatic logic [SW-1:0] find_winner(input logic [N-1:0] r, input logic [SW-1:0] org);
    logic [SW-1:0] win;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(org) + k;
      if (idx >= N) idx = idx - N;
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
    return win;
  endfunction

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    start  = 1'b0;
    origin = ptr_q;
    winner = '0;

    case (state_q)
      IDLE: begin
        if (|req_i) start = 1'b1;
      end
      OWNED: begin
        if (!req_i[sel_q]) begin
          if (|req_i) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            sel_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
          if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
            // Owner's own request stays in the search; origin sel+1 puts it last.
            if (|(req_i & ~grant_q)) begin
              start  = 1'b1;
              origin = wrap_inc(sel_q);
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (start) begin
      winner  = find_winner(req_i, origin);
      state_d = OWNED;
      grant_d = N'(1) << winner;
      sel_d   = winner;
      busy_d  = 1'b1;
      ptr_d   = wrap_inc(winner);
`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
      hold_cnt_d = '0;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign grant_o    = grant_q;
  assign sel_o      = sel_q;
  assign busy_o     = busy_q;
  assign data_out_o = busy_q ? data_in_i[sel_q*W +: W] : {W{1'b0}};

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=8, MAX_HOLD=8); expectations are hand-computed constants.
module tb_rr_mux_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int MAX_HOLD = 8;
  localparam logic [N*W-1:0] PATTERN = 32'h44_33_22_11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = PATTERN;
  logic [N-1:0]   grant;
  logic [1:0]     sel;
  logic           busy;
  logic [W-1:0]   data_out;

  int errors = 0;
  int checks = 0;

  rr_mux_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .data_in_i  (data_in),
    .grant_o    (grant),
    .sel_o      (sel),
    .busy_o     (busy),
    .data_out_o (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_owner(input string tag, input int idx, input logic [W-1:0] d);
    check({tag, " grant"}, 32'(grant), 32'(1) << idx);
    check({tag, " sel"}, 32'(sel), 32'(idx));
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " data_out"}, 32'(data_out), 32'(d));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " grant"}, 32'(grant), 32'd0);
    check({tag, " sel"}, 32'(sel), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " data_out"}, 32'(data_out), 32'd0);
  endtask

  initial begin
    // Reset with all requests pending.
    req = 4'b1111;
    #12;
    expect_idle("reset");
    #10 rst_n = 1'b1;            // t=22, between edges
    step();
    expect_owner("first_grant", 0, 8'h11);

    // Rotation: each owner holds two cycles then drops for one.
    step();               expect_owner("rot0_hold", 0, 8'h11);
    req = 4'b1110; step(); expect_owner("rot1", 1, 8'h22);
    req = 4'b1111; step(); expect_owner("rot1_hold", 1, 8'h22);
    req = 4'b1101; step(); expect_owner("rot2", 2, 8'h33);
    req = 4'b1111; step(); expect_owner("rot2_hold", 2, 8'h33);
    req = 4'b1011; step(); expect_owner("rot3", 3, 8'h44);
    req = 4'b1111; step(); expect_owner("rot3_hold", 3, 8'h44);
    req = 4'b0111; step(); expect_owner("rot0_wrap", 0, 8'h11);

    // Release everything, then idle with data_in all ones.
    req = 4'b0000; step(); expect_idle("release");
    data_in = '1;
    #1 check("idle_comb data_out", 32'(data_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle data_out", 32'(data_out), 32'd0);
      check("idle busy", 32'(busy), 32'd0);
    end
    data_in = PATTERN;

    // Single requester 2 for five cycles.
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_owner("single", 2, 8'h33);
    end
    data_in[23:16] = 8'hA5;
    #1 check("single data_follow", 32'(data_out), 32'hA5);
    data_in = PATTERN;
    req = 4'b0000; step(); expect_idle("single_release");

    // Hold limit: requesters 0 and 1 held high (ptr=3, so 0 wins first).
    req = 4'b0011;
`ifdef RR_MUX_ARBITER_HOLD_LIMIT_EN
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < MAX_HOLD; i++) begin
        step();
        expect_owner((r % 2 == 0) ? "hold_r0" : "hold_r1", r % 2, (r % 2 == 0) ? 8'h11 : 8'h22);
      end
    end
`else
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      step();
      expect_owner("hold_none", 0, 8'h11);
    end
`endif
    req = 4'b0000; step(); expect_idle("hold_release");

    // Mid-grant asynchronous reset while sel=3.
    req = 4'b1000; step(); expect_owner("pre_reset", 3, 8'h44);
    #2 rst_n = 1'b0;
    #1 expect_idle("async_reset");
    req = 4'b1010;
    #2 rst_n = 1'b1;             // released mid-cycle, before the next edge
    step();
    expect_owner("post_reset", 1, 8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one W-bit 2:1-style mux datapath, generalised to N inputs, between N requesters. It registers a one-hot grant and a binary select, steers the granted requester's data to a single output, and rotates priority so that no requester starves. It sits in front of the mux primitives and owns their select line; the mux itself stays purely combinational.

## Interface
- N, 4, number of requesters (2..16)
- W, 8, data width per requester
- MAX_HOLD, 8, max consecutive grant cycles per owner when the hold limit is compiled in (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  level request per requester; held high while the requester wants the resource
- data_in  input  N*W  flattened inputs; requester i occupies bits [i*W +: W]
- grant  output  N  registered one-hot grant; all-zero when idle
- sel  output  clog2(N)  registered binary index of the current owner; 0 when idle
- busy  output  1  registered; high while any grant is active
- data_out  output  W  data_in slice selected by sel when busy, else 0 (combinational from registers and data_in)

## Operation
- State machine, two states:
  - IDLE: grant=0, busy=0. On a clock edge with req≠0, pick the winner, go to OWNED.
  - OWNED: owner = sel. Go to IDLE if req[sel]=0 and no other req. If req[sel]=0 and other requests are pending, switch directly to the next winner with no idle bubble.
- Winner search: the first set req bit starting at index ptr, wrapping N-1→0. On every new grant to index i, ptr ← (i+1) mod N.
- Registers: state, grant, sel, busy, ptr, hold_cnt (clog2(MAX_HOLD+1) bits).
- hold_cnt clears to 0 on every new grant. It increments each cycle the same owner keeps the grant and saturates at MAX_HOLD-1.
- Requests from non-owners never preempt the owner, except through the hold limit (see Configuration).
- data_out = busy ? data_in[sel*W +: W] : {W{1'b0}}.
- No illegal states: an encoding with grant≠onehot(sel) while busy cannot be reached. Default branches return to IDLE with all outputs cleared.

## Timing
- Reset (asynchronous assert, synchronous release at the clk edge): grant=0, sel=0, busy=0, ptr=0, hold_cnt=0, state=IDLE, so data_out=0.
- Latency: req rising at cycle t (sampled at edge t) gives grant/busy/sel valid after edge t. data_out follows in the same cycle.
- Release: req[sel] low sampled at edge t gives a grant change at edge t (to IDLE or to the next winner).
- Simultaneous requests: resolved by ptr order only. Index value is irrelevant except as the search origin.
- Owner re-request: an owner that drops req and raises it again on the next cycle competes normally, and its ptr position puts it last.
- Reset mid-grant: all outputs go to 0 immediately (asynchronous). The first grant after release starts the search at index 0.
- req changes between edges have no effect until the next edge. data_in changes propagate to data_out combinationally.

## Configuration
- RR_MUX_ARBITER_HOLD_LIMIT_EN defined:
  - When hold_cnt = MAX_HOLD-1 and any other req bit is set, the grant moves at the next edge to the next winner, searched from sel+1.
  - The former owner's still-high req is treated as a normal pending request.
  - With no other request pending, the owner keeps the grant indefinitely (hold_cnt saturated).
- RR_MUX_ARBITER_HOLD_LIMIT_EN undefined:
  - hold_cnt is not implemented.
  - The owner keeps the grant until it drops req; no preemption ever occurs.

## Test plan
- Reset: rst_n=0 with req=4'b1111 → grant=0, sel=0, busy=0, data_out=0. Release with req=4'b1111 → after the first edge, grant=4'b0001, data_out=data_in[7:0].
- Rotation: req=4'b1111 held. Each owner drops req for one cycle after 2 cycles of ownership → grant order 0001→0010→0100→1000→0001, with no idle cycle between grants.
- Single requester: req=4'b0100 for 5 cycles, then 0 → grant=0100 and sel=2 for 5 cycles, then grant=0 and busy=0 on the next edge. Also check data_out = data_in[23:16] while granted.
- Hold limit (macro defined, MAX_HOLD=8): req=4'b0011 held steady → requester 0 is granted for exactly 8 cycles, then requester 1 for 8, alternating. Without the macro, requester 0 holds forever.
- Mid-grant reset: assert rst_n=0 asynchronously while sel=3 → outputs go to 0 before the next edge. After release, with req=4'b1010, the first grant is 0010.
- Idle output: with req=0 and data_in all ones → data_out=0 and busy=0 on every cycle.
